// File: rtl/output_drain_pkg.sv
// Shared definitions for the output-buffer drain: FSM encoding, ring depth
// and the width helpers that the buffer and the drain must agree on.
package output_drain_pkg;

  // Tiles held by the output buffer's write ring.
  localparam int NUM_TILES = 4;

  // Drain FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_LAT  = 2'd2;
  localparam logic [1:0] ST_TX   = 2'd3;

  // Element width of an accumulated result (9 bits at 3x3 with 8-bit operands).
  function automatic int calc_output_width(input int matrix_size, input int input_width);
    return $clog2(matrix_size * (2 ** input_width)) - 1;
  endfunction

  // Row-address width covering NUM_TILES tiles of matrix_size rows.
  function automatic int calc_addr_width(input int matrix_size);
    return $clog2((matrix_size * matrix_size) << 2);
  endfunction

endpackage

// File: rtl/output_drain_if.sv
// Result-row stream from the drain toward the DDR write path.
//
// Handshake: a beat transfers on every rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data, m_addr and m_last
// hold their values and m_valid stays high until that transfer happens.
// m_valid never depends combinationally on m_ready.
interface output_drain_if #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 32
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_addr,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_addr,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/output_drain_pending_ctr.sv
// Count of completed tiles waiting to be drained, with a sticky overflow flag
// for completions that arrive while the count is already at ring depth.
module drain_pending_ctr #(
  parameter int NUM_TILES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,       // tile-complete event
  input  logic       dec,       // drain starts a tile at row 0
  output logic [2:0] count,
  output logic       overflow
);

  localparam logic [2:0] FULL_COUNT = 3'(NUM_TILES);

  logic inc_ok;
  logic inc_drop;

  // An event that finds the counter full is dropped rather than wrapping.
  always_comb begin
    inc_ok   = inc && (count != FULL_COUNT);
    inc_drop = inc && (count == FULL_COUNT);
  end

  // Increment and decrement in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (inc_ok && !dec) begin
        count <= count + 3'd1;
      end else if (!inc_ok && dec && (count != 3'd0)) begin
        count <= count - 3'd1;
      end
      if (inc_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_drain.sv
// Read-side drain of the systolic-array output buffer: waits for a full tile,
// reads its rows through the buffer's registered read port and streams them
// out with their DDR word addresses.
module output_drain
  import output_drain_pkg::*;
#(
  parameter int MATRIX_SIZE    = 3,
  parameter int INPUT_WIDTH    = 8,
  parameter int ADDR_WIDTH     = calc_addr_width(MATRIX_SIZE),
  parameter int OUTPUT_WIDTH   = calc_output_width(MATRIX_SIZE, INPUT_WIDTH),
  parameter int DDR_ADDR_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DDR_ADDR_WIDTH-1:0]           base_addr,
  input  logic [MATRIX_SIZE-1:0]              is_full,
  output logic                                read_en,
  output logic [ADDR_WIDTH-1:0]               read_addr,
  input  logic [MATRIX_SIZE*OUTPUT_WIDTH-1:0] qk_result_read,
  output_drain_if.master                      m,
  output logic                                busy,
  output logic                                overflow,
  output logic [1:0]                          state_dbg
);

  localparam int ROW_W  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int TILE_W = $clog2(NUM_TILES);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(MATRIX_SIZE - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  logic [1:0]                          state;
  logic [1:0]                          state_n;
  logic [ROW_W-1:0]                    row;
  logic [TILE_W-1:0]                   tile;
  logic [DDR_ADDR_WIDTH-1:0]           base_q;
  logic [MATRIX_SIZE*OUTPUT_WIDTH-1:0] data_q;
  logic                                full_d;
  logic [2:0]                          pend_count;
  logic                                tile_evt;
  logic                                go;
  logic                                last_row;
  logic                                accept;
  logic                                enter_rd0;
  logic [DDR_ADDR_WIDTH-1:0]           row_off;

  // Tile-complete detection: rising edge of the all-columns-full level.
  always_comb begin
    tile_evt  = (&is_full) && !full_d;
    go        = (pend_count != 3'd0) || tile_evt;
    last_row  = (row == LAST_ROW);
    accept    = (state == ST_TX) && m.m_ready;
    enter_rd0 = ((state == ST_IDLE) && go) || (accept && last_row && go);
    row_off   = DDR_ADDR_WIDTH'(tile) * DDR_ADDR_WIDTH'(MATRIX_SIZE)
              + DDR_ADDR_WIDTH'(row);
  end

  drain_pending_ctr #(
    .NUM_TILES (NUM_TILES)
  ) u_pending (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (tile_evt),
    .dec      (enter_rd0),
    .count    (pend_count),
    .overflow (overflow)
  );

  // Next-state logic: one read, one latency cycle, then hold until accepted.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (go) state_n = ST_RD;
      ST_RD:   state_n = ST_LAT;
      ST_LAT:  state_n = ST_TX;
      ST_TX: begin
        if (m.m_ready) begin
          if (!last_row)  state_n = ST_RD;
          else if (go)    state_n = ST_RD;
          else            state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, row/tile position, latched base address and the captured row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      row    <= '0;
      tile   <= '0;
      base_q <= '0;
      data_q <= '0;
      full_d <= 1'b0;
    end else begin
      state  <= state_n;
      full_d <= &is_full;
      if ((state == ST_IDLE) && go) begin
        base_q <= base_addr;
      end
      if (state == ST_LAT) begin
        data_q <= qk_result_read;
      end
      if (accept) begin
        if (last_row) begin
          row  <= '0;
          tile <= (tile == LAST_TILE) ? '0 : tile + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from registered state so they are glitch-free and
  // stable for the whole TX hold.
  always_comb begin
    read_en   = (state == ST_RD);
    read_addr = (state == ST_RD) ? ADDR_WIDTH'(row_off) : '0;
    m.m_valid = (state == ST_TX);
    m.m_data  = data_q;
    m.m_addr  = base_q + row_off;
    m.m_last  = (state == ST_TX) && last_row;
    busy      = (state != ST_IDLE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: buffer read-port model, tile-level scoreboard,
// a table of drain scenarios and hand-written multi-cycle corner cases.
module tb_output_drain;
  import output_drain_pkg::*;

  localparam int MS  = 3;
  localparam int OW  = 9;
  localparam int DW  = MS * OW;
  localparam int AW  = 6;
  localparam int DAW = 32;

  typedef struct packed {
    logic [DAW-1:0] addr;
    logic [DW-1:0]  data;
    logic           last;
    logic [AW-1:0]  row;
  } beat_t;

  typedef struct {
    logic [DAW-1:0] base;
    int             n_evt;
    int             hold;
    int             pct;
    int             exp_beats;
    logic           exp_ovf;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [DAW-1:0] base_addr;
  logic [MS-1:0]  is_full;
  logic           read_en;
  logic [AW-1:0]  read_addr;
  logic [DW-1:0]  qk_result_read;
  logic           busy;
  logic           overflow;
  logic [1:0]     state_dbg;

  output_drain_if #(.DATA_W(DW), .ADDR_W(DAW)) bus ();

  output_drain dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .base_addr      (base_addr),
    .is_full        (is_full),
    .read_en        (read_en),
    .read_addr      (read_addr),
    .qk_result_read (qk_result_read),
    .m              (bus),
    .busy           (busy),
    .overflow       (overflow),
    .state_dbg      (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Buffer read port: data appears the cycle after read_en.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (read_en) qk_result_read <= mem[read_addr];
  end

  // Scoreboard and tile-level reference state.
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  m_active;
  int    m_pend;
  logic  m_ovf;
  int    m_next_tile;
  logic  full_prev;
  int    beats;
  int    rd_since;
  logic  stall_prev;
  beat_t stall_snap;
  vec_t  vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted tile-complete event queues one tile of MS beats;
  // tiles beyond the one in service wait in a queue of depth NUM_TILES.
  task automatic push_tile();
    beat_t b;
    for (int r = 0; r < MS; r++) begin
      b.row  = AW'(m_next_tile * MS + r);
      b.addr = base_addr + DAW'(m_next_tile * MS + r);
      b.data = mem[m_next_tile * MS + r];
      b.last = (r == MS - 1);
      exp_q.push_back(b);
    end
    m_next_tile = (m_next_tile + 1) % NUM_TILES;
  endtask

  task automatic monitor();
    beat_t b;
    logic  evt;
    if (!reset_n) begin
      exp_q.delete();
      m_active    = 1'b0;
      m_pend      = 0;
      m_ovf       = 1'b0;
      m_next_tile = 0;
      full_prev   = 1'b0;
      rd_since    = 0;
      stall_prev  = 1'b0;
      return;
    end
    chk("busy", busy, m_active);
    chk("overflow", overflow, m_ovf);
    chk("read_vs_valid", read_en & bus.m_valid, 0);
    if (stall_prev) begin
      chk("stall_valid", bus.m_valid, 1);
      chk("stall_data", bus.m_data, stall_snap.data);
      chk("stall_addr", bus.m_addr, stall_snap.addr);
      chk("stall_last", bus.m_last, stall_snap.last);
    end
    if (read_en) begin
      rd_since++;
      if (exp_q.size() == 0) chk("read_unexpected", read_en, 0);
      else begin
        chk("read_addr", read_addr, exp_q[0].row);
        chk("read_once", rd_since, 1);
      end
    end
    evt = (&is_full) && !full_prev;
    full_prev = &is_full;
    if (evt) begin
      if (!m_active) begin
        m_active = 1'b1;
        push_tile();
      end else if (m_pend == NUM_TILES) begin
        m_ovf = 1'b1;
      end else begin
        m_pend++;
        push_tile();
      end
    end
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) chk("beat_unexpected", bus.m_valid, 0);
      else begin
        b = exp_q.pop_front();
        chk("beat_data", bus.m_data, b.data);
        chk("beat_addr", bus.m_addr, b.addr);
        chk("beat_last", bus.m_last, b.last);
        chk("read_per_beat", rd_since, 1);
        if (b.last) begin
          if (m_pend > 0) m_pend--;
          else m_active = 1'b0;
        end
      end
      rd_since = 0;
      beats++;
    end
    stall_prev      = bus.m_valid && !bus.m_ready;
    stall_snap.data = bus.m_data;
    stall_snap.addr = bus.m_addr;
    stall_snap.last = bus.m_last;
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    is_full     = '0;
    bus.m_ready = 1'b0;
    cyc();
    chk("reset_ctrl", {read_en, read_addr, bus.m_valid, bus.m_last, busy, overflow, state_dbg}, 0);
    chk("reset_data", bus.m_data, 0);
    chk("reset_addr", bus.m_addr, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    beats = 0;
  endtask

  task automatic pulse_event(input int hold);
    is_full = '1;
    repeat (hold) cyc();
    is_full = '0;
    cyc();
  endtask

  task automatic wait_drain(input int pct);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 600) begin
      bus.m_ready = ($urandom_range(0, 99) < pct);
      cyc();
      n++;
    end
    chk("drain_in_budget", (n < 600), 1);
    chk("drain_idle", busy, 0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int lat;
    int n;
    int drops;
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    base_addr = '0;
    m_active = 1'b0; m_pend = 0; m_ovf = 1'b0; m_next_tile = 0;
    full_prev = 1'b0; beats = 0; rd_since = 0; stall_prev = 1'b0;
    stall_snap = '0;

    vecs[0] = '{base: 32'h0000_0100, n_evt: 1, hold: 1, pct: 100, exp_beats: 3,  exp_ovf: 1'b0};
    vecs[1] = '{base: 32'h0000_0200, n_evt: 2, hold: 3, pct: 60,  exp_beats: 6,  exp_ovf: 1'b0};
    vecs[2] = '{base: 32'h0000_0000, n_evt: 5, hold: 1, pct: 80,  exp_beats: 15, exp_ovf: 1'b0};
    vecs[3] = '{base: 32'hFFFF_FFFE, n_evt: 2, hold: 2, pct: 50,  exp_beats: 6,  exp_ovf: 1'b0};
    vecs[4] = '{base: 32'h0000_1000, n_evt: 4, hold: 1, pct: 30,  exp_beats: 12, exp_ovf: 1'b0};

    // Table-driven drains with random backpressure and event spacing.
    foreach (vecs[v]) begin
      do_reset();
      base_addr = vecs[v].base;
      for (int e = 0; e < vecs[v].n_evt; e++) begin
        bus.m_ready = ($urandom_range(0, 99) < vecs[v].pct);
        pulse_event(vecs[v].hold);
        repeat ($urandom_range(0, 4)) cyc();
      end
      wait_drain(vecs[v].pct);
      chk("vec_beats", beats, vecs[v].exp_beats);
      chk("vec_overflow", overflow, vecs[v].exp_ovf);
      chk("vec_queue_empty", exp_q.size(), 0);
    end

    // Single tile: first m_valid three cycles after the event.
    do_reset();
    base_addr   = 32'h100;
    bus.m_ready = 1'b1;
    is_full     = '1;
    cyc();
    is_full = '0;
    lat = 1;
    while (!bus.m_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("first_valid_latency", lat, 3);
    chk("first_addr", bus.m_addr, 32'h100);
    wait_drain(100);
    chk("single_beats", beats, 3);

    // Backpressure: five stalled cycles hold the beat; monitor checks stability.
    do_reset();
    base_addr = 32'h300;
    pulse_event(1);
    n = 0;
    while (!bus.m_valid && n < 20) begin
      cyc();
      n++;
    end
    repeat (5) cyc();
    chk("bp_valid_held", bus.m_valid, 1);
    chk("bp_addr_held", bus.m_addr, 32'h300);
    chk("bp_no_beat", beats, 0);
    wait_drain(100);
    chk("bp_beats", beats, 3);

    // Back-to-back: second event mid-drain, busy never drops.
    do_reset();
    base_addr   = 32'h500;
    bus.m_ready = 1'b1;
    pulse_event(1);
    cyc();
    pulse_event(1);
    drops = 0;
    repeat (14) begin
      if (!busy) drops++;
      cyc();
    end
    chk("b2b_busy_drops", drops, 0);
    wait_drain(100);
    chk("b2b_beats", beats, 6);

    // Partial full flags are ignored; a held full level is one event.
    do_reset();
    base_addr = 32'h700;
    is_full   = 3'b011;
    repeat (4) cyc();
    is_full = 3'b110;
    repeat (4) cyc();
    chk("partial_busy", busy, 0);
    bus.m_ready = 1'b1;
    pulse_event(6);
    wait_drain(100);
    chk("held_level_beats", beats, 3);

    // Overflow: one tile in service plus four queued, the sixth is dropped.
    do_reset();
    base_addr = 32'h40;
    for (int e = 0; e < 6; e++) pulse_event(1);
    chk("ovf_set", overflow, 1);
    wait_drain(100);
    chk("ovf_beats", beats, 15);
    chk("ovf_sticky", overflow, 1);

    // Reset during row 1 of tile 2, then restart from tile 0 row 0.
    do_reset();
    base_addr = 32'h80;
    for (int e = 0; e < 3; e++) pulse_event(1);
    n = 0;
    while (!(bus.m_valid && bus.m_addr == 32'h87) && n < 300) begin
      bus.m_ready = bus.m_valid;
      cyc();
      n++;
    end
    bus.m_ready = 1'b0;
    chk("mid_tx_reached", bus.m_addr, 32'h87);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {read_en, read_addr, bus.m_valid, bus.m_last, busy, overflow, state_dbg}, 0);
    chk("async_rst_data", bus.m_data, 0);
    chk("async_rst_addr", bus.m_addr, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    beats = 0;
    bus.m_ready = 1'b1;
    pulse_event(1);
    wait_drain(100);
    chk("post_rst_beats", beats, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
